// File: rtl/usb_hid_key_scheduler.sv
// Round-robin key-event arbiter, event FIFO and press/hold/release/gap report
// sequencer feeding the EP81 boot-keyboard byte stream.
module usb_hid_key_scheduler #(
  parameter int FIFO_AW     = 3,
  parameter int HOLD_CYCLES = 600000,
  parameter int GAP_CYCLES  = 600000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               usb_rstn,
  input  logic [15:0]        a_key_value,
  input  logic               a_key_valid,
  output logic               a_key_ready,
  input  logic [15:0]        b_key_value,
  input  logic               b_key_valid,
  output logic               b_key_ready,
  output logic [7:0]         ep81_data,
  output logic               ep81_valid,
  input  logic               ep81_ready,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [FIFO_AW:0] FULL_LVL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRESS, S_HOLD, S_RELEASE, S_GAP
  } state_t;

  state_t              state, state_next;
  logic [2:0]          idx, idx_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic [15:0]         report;
  logic [15:0]         mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    level;
  logic                last_b;
  logic                flush, full, empty;
  logic                grant_a, grant_b, push, pop;
  logic [15:0]         push_value;

  assign flush = rst | ~usb_rstn;
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);

  // Readies come from the registered level, so a same-cycle pop never frees a slot early.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!flush && !full) begin
      if (a_key_valid && (!b_key_valid || last_b)) grant_a = 1'b1;
      else if (b_key_valid)                        grant_b = 1'b1;
    end
  end

  assign a_key_ready = grant_a;
  assign b_key_ready = grant_b;
  assign push        = grant_a | grant_b;
  assign push_value  = grant_a ? a_key_value : b_key_value;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          idx_next   = 3'd0;
          state_next = S_PRESS;
        end
      end
      S_PRESS, S_RELEASE: begin
        if (ep81_ready) begin
          if (idx == 3'd7) begin
            idx_next   = 3'd0;
            cnt_next   = '0;
            state_next = (state == S_PRESS) ? S_HOLD : S_GAP;
          end else begin
            idx_next = idx + 3'd1;
          end
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          idx_next   = 3'd0;
          state_next = S_RELEASE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_next = S_IDLE;
        else                 cnt_next   = cnt + CW'(1);
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (flush) begin
      state  <= S_IDLE;
      idx    <= 3'd0;
      cnt    <= '0;
      report <= 16'h0000;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      last_b <= 1'b1;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
        last_b <= grant_b;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
        report <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + (FIFO_AW + 1)'(1);
        2'b01:   level <= level - (FIFO_AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and level alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_value;
  end

  always_comb begin
    ep81_valid = (state == S_PRESS) || (state == S_RELEASE);
    ep81_data  = 8'h00;
    if (state == S_PRESS) begin
      case (idx)
        3'd0:    ep81_data = report[15:8];
        3'd2:    ep81_data = report[7:0];
        default: ep81_data = 8'h00;
      endcase
    end
  end

  assign busy       = (state != S_IDLE) || !empty;
  assign fifo_level = level;

endmodule

// File: tb/tb_usb_hid_key_scheduler.sv
// Scoreboard bench: arbitration and report expectations come from an event-level
// model; a negedge monitor compares every presented byte, grant and level.
module tb_usb_hid_key_scheduler;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int HOLD  = 4;
  localparam int GAP   = 3;

  logic        clk = 1'b0;
  logic        rst, usb_rstn;
  logic [15:0] a_key_value, b_key_value;
  logic        a_key_valid, b_key_valid;
  logic        a_key_ready, b_key_ready;
  logic [7:0]  ep81_data;
  logic        ep81_valid, ep81_ready;
  logic        busy;
  logic [AW:0] fifo_level;

  always #5 clk = ~clk;

  usb_hid_key_scheduler #(
    .FIFO_AW(AW), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .usb_rstn(usb_rstn),
    .a_key_value(a_key_value), .a_key_valid(a_key_valid), .a_key_ready(a_key_ready),
    .b_key_value(b_key_value), .b_key_valid(b_key_valid), .b_key_ready(b_key_ready),
    .ep81_data(ep81_data), .ep81_valid(ep81_valid), .ep81_ready(ep81_ready),
    .busy(busy), .fifo_level(fifo_level)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Event-level reference model
  logic [15:0] evq[$];
  bit          m_last_b = 1'b1;
  bit          in_event = 1'b0;
  logic [15:0] cur = 16'h0;
  int          pos = 0;
  int          ev_done = 0;
  int          gap_left = 0;
  int          low_cnt = 0;
  bit          watch_hold = 1'b0, watch_gap = 1'b0, gap_exact = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h0;

  function automatic logic [7:0] press_byte(input logic [15:0] ev, input int p);
    if (p == 0) return ev[15:8];
    if (p == 2) return ev[7:0];
    return 8'h00;
  endfunction

  always @(negedge clk) begin
    if (rst || !usb_rstn) begin
      check("flush_a_ready", a_key_ready, 0);
      check("flush_b_ready", b_key_ready, 0);
      evq.delete();
      m_last_b   = 1'b1;
      in_event   = 1'b0;
      pos        = 0;
      gap_left   = 0;
      watch_hold = 1'b0;
      watch_gap  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      bit exp_a, exp_b;
      if (prev_stall) begin
        check("stall_valid", ep81_valid, 1);
        check("stall_data", ep81_data, prev_data);
      end
      if (!ep81_valid) check("idle_data_zero", ep81_data, 0);

      check("busy", busy, in_event || evq.size() > 0 || gap_left > 0);
      if (gap_left > 0) gap_left--;

      if (ep81_valid && !in_event) begin
        if (evq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_start: report began with no queued event at t=%0t", $time);
        end else begin
          cur      = evq.pop_front();
          in_event = 1'b1;
          pos      = 0;
        end
        if (watch_gap) begin
          if (gap_exact) check("gap_len", low_cnt, GAP + 1);
          else           check("gap_min", low_cnt >= GAP + 1, 1);
          watch_gap = 1'b0;
        end
      end
      if (ep81_valid && watch_hold) begin
        check("hold_len", low_cnt, HOLD);
        watch_hold = 1'b0;
      end
      if (!ep81_valid && (watch_hold || watch_gap)) low_cnt++;

      if (ep81_valid && ep81_ready && in_event) begin
        check("byte", ep81_data, (pos < 8) ? press_byte(cur, pos) : 8'h00);
        pos++;
        if (pos == 8) begin
          watch_hold = 1'b1;
          low_cnt    = 0;
        end
        if (pos == 16) begin
          in_event  = 1'b0;
          pos       = 0;
          ev_done++;
          gap_left  = GAP;
          watch_gap = 1'b1;
          gap_exact = 1'b0;
          low_cnt   = 0;
        end
      end

      check("fifo_level", fifo_level, evq.size());

      // Arbitration rule: a lone requester wins; on a tie, whoever did not win last
      exp_a = 1'b0;
      exp_b = 1'b0;
      if (evq.size() < DEPTH) begin
        if (a_key_valid && b_key_valid) begin
          exp_a = m_last_b;
          exp_b = !m_last_b;
        end else begin
          exp_a = a_key_valid;
          exp_b = b_key_valid;
        end
      end
      check("a_ready", a_key_ready, exp_a);
      check("b_ready", b_key_ready, exp_b);
      if (exp_a) begin evq.push_back(a_key_value); m_last_b = 1'b0; end
      if (exp_b) begin evq.push_back(b_key_value); m_last_b = 1'b1; end

      if (watch_gap && low_cnt <= GAP && evq.size() > 0) gap_exact = 1'b1;
      prev_stall = ep81_valid && !ep81_ready;
      prev_data  = ep81_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [15:0] v);
    int b = 0;
    a_key_value = v;
    a_key_valid = 1'b1;
    do begin
      @(negedge clk);
      b++;
    end while (!a_key_ready && b < 400);
    if (!a_key_ready) begin
      n_checks++;
      $display("FAIL push_timeout: a_key_ready stayed 0 for value 0x%0h", v);
    end
    tick();
    a_key_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    tick();
    while (busy && b < budget) begin
      tick();
      b++;
    end
    if (busy) begin
      n_checks++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    int base;
    rst = 1'b1; usb_rstn = 1'b1; ep81_ready = 1'b1;
    a_key_valid = 1'b0; b_key_valid = 1'b0;
    a_key_value = 16'h0; b_key_value = 16'h0;
    tick();
    do_reset();
    @(negedge clk);
    check("reset_level", fifo_level, 0);
    check("reset_busy", busy, 0);
    check("reset_valid", ep81_valid, 0);
    tick();

    // Single shift+'a' event
    push_a(16'h0204);
    wait_idle(200);

    // Tie arbitration from a fresh reset: A first, then alternating
    do_reset();
    a_key_value = 16'h0004; b_key_value = 16'h0005;
    a_key_valid = 1'b1;     b_key_valid = 1'b1;
    repeat (40) tick();
    a_key_valid = 1'b0;     b_key_valid = 1'b0;
    wait_idle(1000);

    // Randomized requesters with random EP81 back-pressure
    repeat (500) begin
      a_key_valid = ($urandom_range(0, 3) == 0);
      b_key_valid = ($urandom_range(0, 3) == 0);
      a_key_value = 16'($urandom);
      b_key_value = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      ep81_ready  = 1'($urandom_range(0, 1));
      tick();
    end
    a_key_valid = 1'b0; b_key_valid = 1'b0;
    repeat (300) begin
      ep81_ready = 1'($urandom_range(0, 1));
      tick();
    end
    ep81_ready = 1'b1;
    wait_idle(2000);

    // Repeated identical key
    repeat (3) push_a(16'h0004);
    wait_idle(300);

    // Flush after byte 3 of a press report with events still queued
    push_a(16'h0206);
    push_a(16'h0207);
    push_a(16'h0208);
    b = 0;
    while (pos < 4 && b < 100) begin
      tick();
      b++;
    end
    usb_rstn = 1'b0;
    repeat (3) tick();
    usb_rstn = 1'b1;
    tick();
    push_a(16'h0009);
    wait_idle(300);

    // Push landing on the IDLE cycle that pops the single queued event
    push_a(16'h0111);
    push_a(16'h0222);
    base = ev_done;
    b = 0;
    while (ev_done == base && b < 200) begin
      tick();
      b++;
    end
    repeat (3) tick();
    a_key_value = 16'h0333;
    a_key_valid = 1'b1;
    tick();
    a_key_valid = 1'b0;
    @(negedge clk);
    check("simul_push_pop_level", fifo_level, 1);
    wait_idle(300);

    @(negedge clk);
    check("final_level", fifo_level, 0);
    check("final_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_hid_key_scheduler.md
# usb_hid_key_scheduler

Sequencer and arbiter in front of the HID keyboard IN endpoint (EP81) of the USB full-speed core. It accepts key events from two independent requesters, arbitrates them round-robin into a small FIFO, and turns each event into a timed pair of 8-byte boot-keyboard reports: press, hold, release, gap. The EP81 byte stream is driven with a valid/ready handshake. Because a release report always follows each press, repeated identical keys register as separate keystrokes at the host.

## Interface
- `FIFO_AW`, 3: FIFO address width; depth = 2^FIFO_AW entries.
- `HOLD_CYCLES`, 600000: clk cycles between the end of the press report and the start of the release report; must be ≥1 (10 ms at 60 MHz).
- `GAP_CYCLES`, 600000: clk cycles after the release report before the next event may start; must be ≥1.
- `clk`  in  1  system clock, 60 MHz.
- `rst`  in  1  reset, synchronous, active-high.
- `usb_rstn`  in  1  connection status from the USB core; 0 acts as a synchronous flush.
- `a_key_value`  in  16  requester A event: [15:8] modifier byte, [7:0] HID usage code.
- `a_key_valid`  in  1  requester A event valid.
- `a_key_ready`  out  1  requester A event accepted this cycle.
- `b_key_value`  in  16  requester B event, same format as A.
- `b_key_valid`  in  1  requester B event valid.
- `b_key_ready`  out  1  requester B event accepted this cycle.
- `ep81_data`  out  8  report byte to the EP81 port.
- `ep81_valid`  out  1  report byte valid.
- `ep81_ready`  in  1  EP81 port accepts the byte.
- `busy`  out  1  FSM not in IDLE, or FIFO not empty.
- `fifo_level`  out  FIFO_AW+1  number of queued events, 0..2^FIFO_AW.

## Operation
- **Flush condition.** `rst`=1 or `usb_rstn`=0 is a flush.
  - Empties the FIFO.
  - Sets the FSM to IDLE and clears the byte index and counters.
  - Sets the round-robin pointer to "last granted = B", so A wins the first tie.
  - All outputs go to 0: `a_key_ready`, `b_key_ready`, `ep81_valid`, `ep81_data`, `busy` and `fifo_level`.
  - A flush in the middle of a report aborts it immediately. The remaining bytes are not sent.
- **Arbitration.**
  - At most one push per cycle, and only when the FIFO is not full and there is no flush.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester not granted last time wins, and the pointer updates on every grant.
  - `x_key_ready` = grant. It may depend combinationally on both valids. A requester must not make its valid depend on its ready.
  - The event is written on the cycle where `x_key_valid` and `x_key_ready` are both 1.
- **FIFO.** First-in first-out. A push and a pop in the same cycle are allowed, and `fifo_level` stays unchanged.
- **Report formats.**
  - Press report bytes 0..7: modifier, 0x00, usage, 0x00, 0x00, 0x00, 0x00, 0x00.
  - Release report: eight 0x00 bytes.
- **FSM states.**
  - IDLE: if the FIFO is non-empty, pop the head into the report register, set byte index = 0, and go to PRESS.
  - PRESS: `ep81_valid`=1 and `ep81_data` = press byte[index]. The index increments on each `ep81_valid`&`ep81_ready`. When byte 7 is accepted, go to HOLD and clear the counter.
  - HOLD: `ep81_valid`=0. Count up. When count = HOLD_CYCLES−1, go to RELEASE with index = 0.
  - RELEASE: same as PRESS but with zero bytes. When byte 7 is accepted, go to GAP.
  - GAP: `ep81_valid`=0. Count GAP_CYCLES cycles, then go to IDLE.
- **Data output.** `ep81_data` is 0x00 whenever `ep81_valid`=0. `ep81_data` and `ep81_valid` stay stable while `ep81_ready`=0.
- **Event values.** An event with value 0x0000 is still processed: the press report is all zeros, followed by the normal hold, release and gap.
- **Widths.** Counters are wide enough for max(HOLD_CYCLES, GAP_CYCLES). The byte index is 3 bits and stops at 7; it never wraps into a 9th byte.

## Timing
- **Push latency.** After a push, `fifo_level` increments on the next edge.
- **Start latency.** From IDLE with a non-empty FIFO: pop on cycle T, first `ep81_valid`=1 on cycle T+1.
- **Minimum event period** with `ep81_ready` tied to 1: 1 (IDLE) + 8 (PRESS) + HOLD_CYCLES + 8 (RELEASE) + GAP_CYCLES cycles.
- **Back-to-back events.** GAP goes to IDLE, and IDLE pops in that same IDLE cycle. There is no extra idle cycle beyond the IDLE state itself.
- **Back-pressure.** `ep81_ready`=0 stalls the index indefinitely. No timeout. HOLD and GAP do not start until byte 7 is accepted.
- **Full FIFO.** Both readies are 0 when full. A pop in the same cycle does not enable a push; readies are computed from the registered level.
- **Flush.** Takes effect on the edge where it is sampled. Outputs are 0 in the following cycle.

## Test plan
- **Single event.** Test configuration: HOLD_CYCLES=4, GAP_CYCLES=3, `ep81_ready`=1. A pushes 0x0204 (shift+'a').
  - Required stream: 02 00 04 00 00 00 00 00.
  - Then 4 cycles with `ep81_valid` low, then eight 00 bytes, then 3 gap cycles.
  - `busy` falls afterwards.
- **Tie arbitration.** A and B both valid continuously, values 0x0004 and 0x0005, FIFO initially empty.
  - Grants alternate A, B, A, B… until `fifo_level`=8, then both readies are 0.
  - Reports are emitted in usage order 04, 05, 04, 05…
- **Back-pressure.** Toggle `ep81_ready` randomly during PRESS.
  - Exactly 8 bytes are accepted, in order, with data stable during stalls.
  - The HOLD count starts only after the 8th acceptance.
- **Repeated key.** Push 0x0004 three times.
  - Three press/release pairs, each press report separated by a full release report and GAP.
- **Mid-report flush.** Drop `usb_rstn` after byte 3 of a press report.
  - Next cycle: `ep81_valid`=0, `fifo_level`=0, readies 0.
  - After `usb_rstn` returns to 1, a new event restarts cleanly from byte 0.
- **Simultaneous push and pop.** FIFO holds 1 event, FSM in IDLE, A pushes on the same cycle.
  - `fifo_level` stays 1. Both events are reported in order.
